// File: rtl/capture_ctrl.sv
// capture_ctrl: captures a burst of samples into an external RAM, then plays
// them back through a valid/ready output port.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, length               begin a run of `length` samples (ignored when busy)
//   sample_in, sample_valid     capture stream
//   stop                        ends looped playback (looped build only)
//   ram_write_addr, ram_data_in RAM write port; the RAM writes every cycle
//   ram_read_addr, ram_data_out RAM read port, one-cycle registered latency
//   out_data, out_valid, out_ready  playback stream
//   busy, done                  run in progress / one-cycle end-of-run pulse
//
// Build option: define CAPTURE_CTRL_LOOP_EN to repeat playback until stop.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; RAM write port parked
// CAPTURE  | writing valid samples to addresses 0..length-1
// PB_ISSUE | ram_read_addr presents the current playback index
// PB_WAIT  | RAM read data arrives and is registered into out_data
// PB_HOLD  | out_valid high until the consumer takes out_data
module capture_ctrl #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0]    sample_in,
    input  logic                     sample_valid,
    input  logic                     stop,
    output logic [ADDRESS_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    output logic [ADDRESS_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    // Top address is reserved as the dump location for idle RAM writes.
    localparam logic [AW-1:0] PARK = '1;

    typedef enum logic [2:0] {IDLE, CAPTURE, PB_ISSUE, PB_WAIT, PB_HOLD} state_t;

    state_t          state_q;
    logic [AW-1:0]   index_q;
    logic [AW-1:0]   len_q;
    logic [AW-1:0]   rd_addr_q;
    logic [DW-1:0]   out_data_q;
    logic            out_valid_q;
    logic            done_q;

    logic            cap_wr;
    logic [AW-1:0]   index_inc;
    logic            last;
    logic [AW-1:0]   next_index;
    logic            end_run;

    assign cap_wr     = (state_q == CAPTURE) && sample_valid;
    assign index_inc  = index_q + {{(AW-1){1'b0}}, 1'b1};
    // len_q <= 2**AW-1, so index_inc never wraps before matching it.
    assign last       = (index_inc == len_q);
    assign next_index = last ? '0 : index_inc;

`ifdef CAPTURE_CTRL_LOOP_EN
    logic stop_q;
    assign end_run = stop_q || stop;
`else
    logic unused_stop;
    assign unused_stop = stop;
    assign end_run     = last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            len_q       <= '0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            len_q   <= length;
                            index_q <= '0;
                            state_q <= CAPTURE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        if (last) begin
                            index_q   <= '0;
                            rd_addr_q <= '0;
                            state_q   <= PB_ISSUE;
                        end else begin
                            index_q <= index_inc;
                        end
                    end
                end
                PB_ISSUE: state_q <= PB_WAIT;
                PB_WAIT: begin
                    out_data_q  <= ram_data_out;
                    out_valid_q <= 1'b1;
                    state_q     <= PB_HOLD;
                end
                PB_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (end_run) begin
                            index_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            // read address is loaded on entry so it holds outside PB_ISSUE
                            index_q   <= next_index;
                            rd_addr_q <= next_index;
                            state_q   <= PB_ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CAPTURE_CTRL_LOOP_EN
    // stop is remembered for the rest of playback and cleared between runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_q <= 1'b0;
        end else if (state_q == PB_ISSUE || state_q == PB_WAIT || state_q == PB_HOLD) begin
            stop_q <= stop_q || stop;
        end else begin
            stop_q <= 1'b0;
        end
    end
`endif

    assign ram_write_addr = cap_wr ? index_q : PARK;
    assign ram_data_in    = cap_wr ? sample_in : '0;
    assign ram_read_addr  = rd_addr_q;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
`timescale 1ns/1ps
module tb_capture_ctrl;
    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int MAXN = 1 << AW;
    localparam logic [AW-1:0] PARK = '1;
`ifdef CAPTURE_CTRL_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] length = '0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          stop = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] ram_write_addr, ram_read_addr;
    logic [DW-1:0] ram_data_in, ram_data_out, out_data;
    logic          out_valid, busy, done;

    always #5 clk = ~clk;

    capture_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .sample_in(sample_in), .sample_valid(sample_valid), .stop(stop),
        .ram_write_addr(ram_write_addr), .ram_data_in(ram_data_in),
        .ram_read_addr(ram_read_addr), .ram_data_out(ram_data_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // RAM: unconditional write, registered read
    logic [DW-1:0] ram [MAXN];
    initial begin
        for (int i = 0; i < MAXN; i++) ram[i] = '0;
        ram_data_out = '0;
    end
    always @(posedge clk) begin
        ram[ram_write_addr] <= ram_data_in;
        ram_data_out        <= ram[ram_read_addr];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_valid"},  32'(out_valid), 32'd0);
        chk({tag, "_data"},   32'(out_data), 32'd0);
        chk({tag, "_raddr"},  32'(ram_read_addr), 32'd0);
        chk({tag, "_waddr"},  32'(ram_write_addr), 32'(PARK));
        chk({tag, "_wdata"},  32'(ram_data_in), 32'd0);
    endtask

    // Behavioural model: phase 0 idle, 1 capturing, 2 playing back.
    // Playback timing: a sample shows up on out_valid 3 cycles after the
    // capture finishes or after the previous sample is taken.
    int            ph = 0, widx = 0, mlen = 0, gap = 0, pidx = 0;
    logic [AW-1:0] raddr_exp = '0;
    logic          done_exp = 1'b0, done_next;
    logic          stop_seen = 1'b0;
    logic [DW-1:0] cap_mem [MAXN];
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
    logic          ev;
    logic [DW-1:0] acc_q [$];
    int            acc_t [$];
    int            done_cnt = 0;
    bit            busy_seen = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ph = 0; raddr_exp = '0; done_exp = 1'b0; stop_seen = 1'b0;
            chk_reset_vals("rst");
        end else begin
            if (done) done_cnt++;
            if (busy) busy_seen = 1;
            ewa = (ph == 1 && sample_valid) ? AW'(widx) : PARK;
            ewd = (ph == 1 && sample_valid) ? sample_in : '0;
            ev  = (ph == 2 && gap == 0);
            if (ph == 2 && gap == 2) raddr_exp = AW'(pidx);
            chk("busy",      32'(busy), 32'(ph != 0));
            chk("done",      32'(done), 32'(done_exp));
            chk("wr_addr",   32'(ram_write_addr), 32'(ewa));
            chk("wr_data",   32'(ram_data_in), 32'(ewd));
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("rd_addr",   32'(ram_read_addr), 32'(raddr_exp));
            if (ev) chk("out_data", 32'(out_data), 32'(cap_mem[pidx]));

            done_next = 1'b0;
            case (ph)
                0: if (start) begin
                    if (length != 0) begin ph = 1; mlen = int'(length); widx = 0; end
                    else done_next = 1'b1;
                end
                1: if (sample_valid) begin
                    cap_mem[widx] = sample_in;
                    widx++;
                    if (widx == mlen) begin ph = 2; gap = 2; pidx = 0; stop_seen = 1'b0; end
                end
                default: begin
                    if (LOOP && stop) stop_seen = 1'b1;
                    if (gap > 0) gap--;
                    else if (out_ready) begin
                        acc_q.push_back(out_data);
                        acc_t.push_back(cyc);
                        if (LOOP && stop_seen) begin ph = 0; done_next = 1'b1; end
                        else if (pidx == mlen - 1) begin
                            if (LOOP) begin pidx = 0; gap = 2; end
                            else begin ph = 0; done_next = 1'b1; end
                        end else begin
                            pidx++; gap = 2;
                        end
                    end
                end
            endcase
            done_exp = done_next;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_rec();
        acc_q.delete(); acc_t.delete(); done_cnt = 0; busy_seen = 0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; length = AW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int maxgap, input bit fixed, input bit noise);
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(0, maxgap);
            sample_valid = 1'b0;
            for (int k = 0; k < g; k++) begin
                if (noise) begin start = ($urandom_range(0, 3) == 0); length = AW'($urandom); end
                tick();
            end
            if (noise) begin start = ($urandom_range(0, 3) == 0); length = AW'($urandom); end
            sample_valid = 1'b1;
            sample_in = fixed ? DW'(8'h11 * (i + 1)) : DW'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready and stop; 2: hold ready low 5 cycles once.
    // stop is raised once only the last of stop_at samples is still outstanding.
    task automatic wait_idle(input int budget, input int mode, input int stop_at);
        int n = 0;
        bit held = 0;
        while (busy && n < budget) begin
            stop = (acc_q.size() + 1 >= stop_at) || (mode == 1 && $urandom_range(0, 7) == 0);
            if (mode == 2 && !held && out_valid) begin
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
                held = 1;
                n += 5;
                continue;
            end
            out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n >= budget), 32'd0);
        out_ready = 1'b1;
        stop = 1'b0;
        tick(); tick();
    endtask

    logic [DW-1:0] e1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n;
        repeat (3) tick();
        chk_reset_vals("init");
        rst_n = 1'b1;
        tick();

        // directed run: 4 samples with gaps, ready held high
        clear_rec();
        do_start(4);
        feed(4, 2, 1, 0);
        wait_idle(200, 0, 4);
        chk("t1_count", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_data", 32'(acc_q[i]), 32'(e1[i]));
        for (int i = 1; i < 4; i++) chk("t1_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd3);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // zero length
        clear_rec();
        do_start(0);
        tick(); tick();
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_busy_seen", 32'(busy_seen), 32'd0);

        // maximum length
        clear_rec();
        do_start(MAXN - 1);
        feed(MAXN - 1, 1, 0, 0);
        wait_idle(3000, 0, MAXN - 1);
        chk("t3_count", 32'(acc_q.size()), 32'(MAXN - 1));
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        // consumer stall
        clear_rec();
        do_start(3);
        feed(3, 1, 0, 0);
        wait_idle(300, 2, 3);
        chk("t4_count", 32'(acc_q.size()), 32'd3);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);

        // reset mid-capture
        do_start(5);
        feed(2, 1, 0, 0);
        rst_n = 1'b0;
        #1 chk_reset_vals("rst_cap");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_rec();
        do_start(2);
        feed(2, 1, 1, 0);
        wait_idle(100, 0, 2);
        chk("t5_count", 32'(acc_q.size()), 32'd2);
        chk("t5_data1", 32'(acc_q[1]), 32'h22);

        // reset mid-hold
        out_ready = 1'b0;
        do_start(3);
        feed(3, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("t6_hold_wait", 32'(n < 20), 32'd1);
        tick(); tick();
        rst_n = 1'b0;
        #1 chk_reset_vals("rst_hold");
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        clear_rec();
        do_start(2);
        feed(2, 2, 1, 0);
        wait_idle(100, 0, 2);
        chk("t6_count", 32'(acc_q.size()), 32'd2);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);

`ifdef CAPTURE_CTRL_LOOP_EN
        // looped playback, stopped during the third pass
        clear_rec();
        do_start(3);
        feed(3, 1, 1, 0);
        n = 0;
        while (acc_q.size() < 6 && n < 200) begin tick(); n++; end
        chk("t7_loop_wait", 32'(n < 200), 32'd1);
        stop = 1'b1;
        wait_idle(100, 0, 0);
        chk("t7_count", 32'(acc_q.size()), 32'd7);
        chk("t7_rep0", 32'(acc_q[3]), 32'h11);
        chk("t7_rep2", 32'(acc_q[5]), 32'h33);
        chk("t7_last", 32'(acc_q[6]), 32'h11);
        chk("t7_done_cnt", 32'(done_cnt), 32'd1);
`endif

        // randomized runs with start noise, random ready and stop
        for (int r = 0; r < 25; r++) begin
            int len = $urandom_range(0, 12);
            clear_rec();
            do_start(len);
            feed(len, 3, 0, 1);
            wait_idle(600, 1, len);
            chk("rnd_done_cnt", 32'(done_cnt), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
